// File: rtl/cndm_msi_irq_gen.sv
// MSI interrupt request generator.
// Latches per-source interrupt pulses, picks one pending source round-robin,
// issues a single one-hot MSI vector request to the PCIe core, and handles
// sent / fail / timeout outcomes. A fail backs off before re-arbitrating.
// A timeout abandons the attempt and bumps a saturating counter.
module cndm_msi_irq_gen #(
  parameter int IRQ_N       = 32,
  parameter int RETRY_DELAY = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IRQ_N-1:0]  irq,
  input  logic [3:0]        cfg_interrupt_msi_enable,
  input  logic [11:0]       cfg_interrupt_msi_mmenable,
  output logic [31:0]       cfg_interrupt_msi_int,
  input  logic              cfg_interrupt_msi_sent,
  input  logic              cfg_interrupt_msi_fail,
  output logic [1:0]        cfg_interrupt_msi_select,
  output logic [2:0]        cfg_interrupt_msi_attr,
  output logic              cfg_interrupt_msi_tph_present,
  output logic [1:0]        cfg_interrupt_msi_tph_type,
  output logic [7:0]        cfg_interrupt_msi_tph_st_tag,
  output logic [7:0]        cfg_interrupt_msi_function_number,
  output logic [IRQ_N-1:0]  irq_pending,
  output logic [15:0]       timeout_count
);

  localparam int IDX_W   = (IRQ_N > 1) ? $clog2(IRQ_N) : 1;
  localparam int CNT_MAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_BACKOFF
  } state_t;

  state_t             state_q, state_d;
  logic [IRQ_N-1:0]   pending_q, pending_d, clr;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [4:0]         vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        tmo_q, tmo_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [2:0]         log_cnt;
  logic [4:0]         vec_mask;
  logic [4:0]         pick_vec;

  // Only function 0 and the low multi-message field are meaningful here.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3]};

  // Reset synchroniser: assertion is immediate, release lands on a clock edge.
  // NOTE: the synchronised reset still drives async clears downstream, so
  // reset assertion stays combinational while release is glitch-free.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // Round-robin search starting just after the last serviced source.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < IRQ_N; k++) begin
      int idx;
      idx = int'(last_q) + 1 + k;
      if (idx >= IRQ_N) idx = idx - IRQ_N;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // Vector fold: allowed count is 1 << min(mmenable, 5); source index is masked.
  always_comb begin
    log_cnt  = (cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : cfg_interrupt_msi_mmenable[2:0];
    vec_mask = 5'((32'd1 << log_cnt) - 32'd1);
    pick_vec = 5'(pick) & vec_mask;
  end

  // Next-state and datapath updates for the request FSM.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    clr     = '0;

    case (state_q)
      S_IDLE: begin
        if (cfg_interrupt_msi_enable[0] && found) begin
          sel_d   = pick;
          vec_d   = pick_vec;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cfg_interrupt_msi_sent) begin
          // Sent wins over a simultaneous fail.
          clr[sel_q] = 1'b1;
          last_d     = sel_q;
          state_d    = S_IDLE;
        end else if (cfg_interrupt_msi_fail) begin
          cnt_d   = '0;
          state_d = S_BACKOFF;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BACKOFF: begin
        if (cnt_q == CNT_W'(RETRY_DELAY - 1)) state_d = S_IDLE;
        else                                  cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A new pulse on a bit being cleared keeps it pending.
    pending_d = (pending_q & ~clr) | irq;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_int_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      sel_q     <= '0;
      last_q    <= IDX_W'(IRQ_N - 1);
      vec_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign cfg_interrupt_msi_int = (state_q == S_REQ) ? (32'd1 << vec_q) : 32'd0;
  assign irq_pending           = pending_q;
  assign timeout_count         = tmo_q;

  assign cfg_interrupt_msi_select          = '0;
  assign cfg_interrupt_msi_attr            = '0;
  assign cfg_interrupt_msi_tph_present     = 1'b0;
  assign cfg_interrupt_msi_tph_type        = '0;
  assign cfg_interrupt_msi_tph_st_tag      = '0;
  assign cfg_interrupt_msi_function_number = '0;

endmodule

// File: tb/tb_cndm_msi_irq_gen.sv
// Directed testbench for cndm_msi_irq_gen with hand-computed expectations.
module tb_cndm_msi_irq_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq;
  logic [3:0]  msi_enable;
  logic [11:0] msi_mmenable;
  logic [31:0] msi_int;
  logic        msi_sent;
  logic        msi_fail;
  logic [1:0]  msi_select;
  logic [2:0]  msi_attr;
  logic        msi_tph_present;
  logic [1:0]  msi_tph_type;
  logic [7:0]  msi_tph_st_tag;
  logic [7:0]  msi_function_number;
  logic [31:0] irq_pending;
  logic [15:0] timeout_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] acc;

  cndm_msi_irq_gen #(
    .IRQ_N(32),
    .RETRY_DELAY(16),
    .TIMEOUT(1024)
  ) dut (
    .clk                               (clk),
    .rst_n                             (rst_n),
    .irq                               (irq),
    .cfg_interrupt_msi_enable          (msi_enable),
    .cfg_interrupt_msi_mmenable        (msi_mmenable),
    .cfg_interrupt_msi_int             (msi_int),
    .cfg_interrupt_msi_sent            (msi_sent),
    .cfg_interrupt_msi_fail            (msi_fail),
    .cfg_interrupt_msi_select          (msi_select),
    .cfg_interrupt_msi_attr            (msi_attr),
    .cfg_interrupt_msi_tph_present     (msi_tph_present),
    .cfg_interrupt_msi_tph_type        (msi_tph_type),
    .cfg_interrupt_msi_tph_st_tag      (msi_tph_st_tag),
    .cfg_interrupt_msi_function_number (msi_function_number),
    .irq_pending                       (irq_pending),
    .timeout_count                     (timeout_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    irq          = '0;
    msi_enable   = 4'h1;
    msi_mmenable = 12'd5;
    msi_sent     = 1'b0;
    msi_fail     = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_pending", irq_pending, 32'h0);
    check("rst_msi_int", msi_int, 32'h0);
    check("rst_timeout", {16'h0, timeout_count}, 32'h0);
    check("const_zero_outputs",
          {8'h0, msi_select, msi_attr, msi_tph_present, msi_tph_type, msi_tph_st_tag, msi_function_number},
          32'h0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single source, full vector range: irq[3] -> vector 3, two cycles later.
    irq = 32'h8;
    tick();
    irq = '0;
    check("s1_pending_latched", irq_pending, 32'h8);
    check("s1_not_early", msi_int, 32'h0);
    tick();
    check("s1_msi_int", msi_int, 32'h8);
    tick();
    check("s1_one_cycle", msi_int, 32'h0);
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    check("s1_pending_cleared", irq_pending, 32'h0);
    tick();
    check("s1_idle_quiet", msi_int, 32'h0);

    // Shared vector (4 vectors): irq[2] and irq[6] both map to vector 2.
    do_reset();
    msi_mmenable = 12'd2;
    irq = 32'h44;
    tick();
    irq = '0;
    tick();
    check("s2_first_msi", msi_int, 32'h4);
    tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    check("s2_irq2_first", irq_pending, 32'h40);
    tick();
    check("s2_second_msi", msi_int, 32'h4);
    tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    check("s2_all_cleared", irq_pending, 32'h0);

    // Fail then backoff of 16 cycles, then reissue.
    msi_mmenable = 12'd5;
    irq = 32'h1;
    tick();
    irq = '0;
    tick();
    check("s3_first_msi", msi_int, 32'h1);
    tick();
    msi_fail = 1'b1;
    tick();
    msi_fail = 1'b0;
    acc = '0;
    repeat (16) begin
      tick();
      acc = acc | msi_int;
    end
    check("s3_backoff_quiet", acc, 32'h0);
    check("s3_pending_kept", irq_pending, 32'h1);
    tick();
    check("s3_reissue", msi_int, 32'h1);
    tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    check("s3_cleared", irq_pending, 32'h0);

    // No response: timeout after 1024 WAIT cycles, then reissue.
    irq = 32'h2;
    tick();
    irq = '0;
    tick();
    check("s4_first_msi", msi_int, 32'h2);
    tick();
    repeat (1023) tick();
    check("s4_no_early_timeout", {16'h0, timeout_count}, 32'h0);
    tick();
    check("s4_timeout_count", {16'h0, timeout_count}, 32'h1);
    check("s4_pending_kept", irq_pending, 32'h2);
    tick();
    check("s4_reissue", msi_int, 32'h2);
    tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    check("s4_cleared", irq_pending, 32'h0);
    check("s4_timeout_held", {16'h0, timeout_count}, 32'h1);

    // Enable low blocks requests while pending accumulates.
    msi_enable = 4'h0;
    irq = 32'h10;
    tick();
    irq = '0;
    acc = '0;
    repeat (5) begin
      tick();
      acc = acc | msi_int;
    end
    check("s5_blocked", acc, 32'h0);
    check("s5_pending", irq_pending, 32'h10);
    msi_enable = 4'h1;
    tick();
    check("s5_enabled_msi", msi_int, 32'h10);
    tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    check("s5_cleared", irq_pending, 32'h0);

    // Reset during WAIT: outputs clear at once, a late sent is ignored.
    irq = 32'h20;
    tick();
    irq = '0;
    tick();
    check("s6_msi", msi_int, 32'h20);
    tick();
    rst_n = 1'b0;
    #1;
    check("s6_rst_msi", msi_int, 32'h0);
    check("s6_rst_pending", irq_pending, 32'h0);
    check("s6_rst_timeout", {16'h0, timeout_count}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    acc = '0;
    repeat (3) begin
      tick();
      acc = acc | msi_int;
    end
    check("s6_sent_ignored_msi", acc, 32'h0);
    check("s6_sent_ignored_pending", irq_pending, 32'h0);
    check("s6_timeout_zero", {16'h0, timeout_count}, 32'h0);
    irq = 32'h80;
    tick();
    irq = '0;
    tick();
    check("s6_post_reset_msi", msi_int, 32'h80);
    tick();
    msi_sent = 1'b1;
    tick();
    msi_sent = 1'b0;
    check("s6_post_reset_cleared", irq_pending, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
